// File: rtl/fetch_if.sv
// ============================================================================
// Module  : fetch_if
// Brief   : Fetch-stage bundle: imem request/response, decode handshake, IF/ID.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               decode_en;
  logic               flush;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               ihit;
  logic [INSTR_W-1:0] iload;
  logic               iREN;
  logic [PC_W-1:0]    iaddr;
  logic [INSTR_W-1:0] instr_o;
  logic [PC_W-1:0]    npc_o;
  logic               valid_o;
  logic               halted_o;

  modport master (
    input  decode_en, flush, redirect, redirect_pc, ihit, iload,
    output iREN, iaddr, instr_o, npc_o, valid_o, halted_o
  );

  modport slave (
    output decode_en, flush, redirect, redirect_pc, ihit, iload,
    input  iREN, iaddr, instr_o, npc_o, valid_o, halted_o
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module  : fetch_stage
// Brief   : MIPS instruction fetch with PC, one-entry skid buffer and IF/ID latch.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HALT_OP  = 6'h3F
) (
  input  logic     CLK,
  input  logic     RST,
  fetch_if.master  bus
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t             state_q;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    npc_q;
  logic               valid_q;
  logic               buf_v_q;
  logic [INSTR_W-1:0] buf_instr_q;
  logic [PC_W-1:0]    buf_npc_q;

  logic [PC_W-1:0]    pc_inc;
  logic               squash;
  logic               hit_halt;

  assign pc_inc   = pc_q + PC_W'(4);
  assign squash   = bus.flush | bus.redirect;
  assign hit_halt = (bus.iload[31:26] == HALT_OP);

  // No request while the skid buffer is full, so one entry is always enough.
  assign bus.iREN     = (state_q == S_RUN) && !buf_v_q && !squash;
  assign bus.iaddr    = pc_q;
  assign bus.instr_o  = instr_q;
  assign bus.npc_o    = npc_q;
  assign bus.valid_o  = valid_q;
  assign bus.halted_o = (state_q == S_HALT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      npc_q       <= '0;
      valid_q     <= 1'b0;
      buf_v_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_npc_q   <= '0;
    end else if (squash) begin
      // A wrong-path HALT is cancelled along with everything in flight.
      state_q <= S_RUN;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
      buf_v_q <= 1'b0;
      if (bus.redirect) begin
        pc_q <= bus.redirect_pc;
      end
    end else if (buf_v_q) begin
      if (bus.decode_en) begin
        instr_q <= buf_instr_q;
        npc_q   <= buf_npc_q;
        valid_q <= 1'b1;
        buf_v_q <= 1'b0;
      end
    end else if (bus.ihit && (state_q == S_RUN)) begin
      if (bus.decode_en) begin
        instr_q <= bus.iload;
        npc_q   <= pc_inc;
        valid_q <= 1'b1;
      end else begin
        buf_instr_q <= bus.iload;
        buf_npc_q   <= pc_inc;
        buf_v_q     <= 1'b1;
      end
      if (hit_halt) begin
        state_q <= S_HALT;
      end else begin
        pc_q <= pc_inc;
      end
    end else if (bus.decode_en) begin
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end
  end

endmodule

`default_nettype wire
